led_fade_drv: RTL and testbench
===============================

LED_FADE_DRV -- requirements
Module: led_fade_drv

Interface
REQ-001 SHALL have parameter STEP_DIV, default 16'd49000, clocks per duty step (legal range 1..65535).
REQ-002 SHALL have parameter PWM_MAX, default 8'd255, full-scale duty and PWM period length in clocks.
REQ-003 SHALL have port sys_clk, input, 1 bit: single system clock (50 MHz).
REQ-004 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port led_in, input, 2 bits: on/off pattern from the flow-LED stage, one bit per channel, synchronous to sys_clk.
REQ-006 SHALL have port led_out, output, 2 bits: PWM-faded LED pins, registered.

Function
REQ-007 SHALL register led_in once (led_q); all channel decisions use led_q, giving 1-cycle input latency.
REQ-008 SHALL run a free prescaler 0..STEP_DIV-1; step_tick is high for one cycle when the count equals STEP_DIV-1, then the count wraps to 0.
REQ-009 SHALL run a free PWM counter 0..PWM_MAX-1 that wraps to 0 after PWM_MAX-1.
REQ-010 SHALL keep an 8-bit duty and a 2-bit state {OFF, RISE, ON, FALL} independently per channel.
REQ-011 OFF: duty=0; if led_q=1, go to RISE on the next edge.
REQ-012 RISE: duty+1 on each step_tick; if duty reaches PWM_MAX, go to ON; if led_q=0, go to FALL without a duty jump.
REQ-013 ON: duty=PWM_MAX; if led_q=0, go to FALL.
REQ-014 FALL: duty-1 on each step_tick; at duty 0, go to OFF; if led_q=1, go to RISE without a duty jump.
REQ-015 Duty SHALL saturate, never wrapping below 0 or above PWM_MAX; a step_tick coinciding with a direction change SHALL apply the new direction.
REQ-016 led_out[i] SHALL be registered (pwm_cnt < duty[i]): duty 0 gives constant low, PWM_MAX gives constant high.
REQ-017 Full fade time SHALL be PWM_MAX*STEP_DIV clocks (default ~0.25 s, within the 0.5 s flow period).

Reset
REQ-018 On sys_rst_n low, SHALL clear immediately: prescaler=0, pwm_cnt=0, led_q=0, duty=0, state=OFF, led_out=inactive level.
REQ-019 Reset asserted mid-fade SHALL abandon the fade; after release each channel restarts from OFF and follows led_q.

Configuration
REQ-020 Macro LED_FADE_ACTIVE_LOW_EN defined: led_out SHALL be inverted (inactive=1, including the reset value) for active-low boards.
REQ-021 Macro LED_FADE_ACTIVE_LOW_EN undefined: led_out SHALL be active-high (inactive=0); internal behaviour is identical in both cases.

Structure
REQ-022 Package led_fade_pkg SHALL hold the state enum type (OFF/RISE/ON/FALL) and the duty width constant (8).
REQ-023 Sub-module led_fade_chan (FSM plus duty register) SHALL be instantiated twice; the prescaler, PWM counter, input register and output register live in led_fade_drv.

Verification (STEP_DIV=2, PWM_MAX=255 unless noted)
REQ-024 Reset, then led_in=2'b00 for 2000 cycles -> led_out constant inactive, both states OFF, duty=0.
REQ-025 led_in 00->01 at cycle T -> ch0 in RISE at T+2; duty 255 and ON at T+2+510 (+-2); ch0 output high fraction increases monotonically; ch1 stays OFF.
REQ-026 ch0 ON, then led_in=00 -> FALL; duty reaches 0 and OFF after 510 (+-2) cycles; led_out[0] constant inactive afterwards.
REQ-027 ch0 at duty 100 in RISE, led_in bit0 drops -> next step duty=99, no jump; re-raise at duty 90 -> next step duty=91.
REQ-028 Pulse sys_rst_n low asynchronously mid-RISE (between clock edges) -> led_out inactive and duty 0 before the next edge; with led_in=01 held, restart from OFF.
REQ-029 Build with LED_FADE_ACTIVE_LOW_EN and repeat REQ-024/REQ-025 -> led_out is the bitwise inverse; reset value 2'b11.

Source files
------------

// File: rtl/led_fade_pkg.sv
// Shared types and constants for the LED fade driver.
package led_fade_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } fade_state_e;

endpackage : led_fade_pkg

// File: rtl/led_fade_chan.sv
// One fade channel: OFF/RISE/ON/FALL state machine plus saturating duty register.
//
// state | meaning
// ------+-------------------------------------------------------------
// OFF   | duty held at 0, waiting for led_i to go high
// RISE  | duty +1 per step_tick until PWM_MAX; led_i low turns around
// ON    | duty held at PWM_MAX, waiting for led_i to go low
// FALL  | duty -1 per step_tick until 0; led_i high turns around
//
// A step_tick landing on the same edge as a turn-around is applied in the
// new direction, so the duty never jumps.
module led_fade_chan
  import led_fade_pkg::*;
#(
  parameter logic [DUTY_W-1:0] PWM_MAX = 8'd255
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              led_i,
  input  logic              step_tick,
  output fade_state_e       state,
  output logic [DUTY_W-1:0] duty
);

  fade_state_e       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;

  // State and duty registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_OFF;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
    end
  end

  // Next-state and saturating duty update.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    case (state_q)
      ST_OFF: begin
        duty_d = '0;
        if (led_i) state_d = ST_RISE;
      end
      ST_RISE: begin
        if (!led_i) begin
          if (duty_q == '0) begin
            state_d = ST_OFF;
          end else begin
            state_d = ST_FALL;
            if (step_tick) begin
              duty_d = duty_q - 1'b1;
              if (duty_q == 8'd1) state_d = ST_OFF;
            end
          end
        end else if (duty_q >= PWM_MAX) begin
          duty_d  = PWM_MAX;
          state_d = ST_ON;
        end else if (step_tick) begin
          duty_d = duty_q + 1'b1;
          if ((duty_q + 8'd1) == PWM_MAX) state_d = ST_ON;
        end
      end
      ST_ON: begin
        duty_d = PWM_MAX;
        if (!led_i) state_d = ST_FALL;
      end
      ST_FALL: begin
        if (led_i) begin
          if (duty_q >= PWM_MAX) begin
            duty_d  = PWM_MAX;
            state_d = ST_ON;
          end else begin
            state_d = ST_RISE;
            if (step_tick) begin
              duty_d = duty_q + 1'b1;
              if ((duty_q + 8'd1) == PWM_MAX) state_d = ST_ON;
            end
          end
        end else if (duty_q == '0) begin
          state_d = ST_OFF;
        end else if (step_tick) begin
          duty_d = duty_q - 1'b1;
          if (duty_q == 8'd1) state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
        duty_d  = '0;
      end
    endcase
  end

  assign state = state_q;
  assign duty  = duty_q;

endmodule : led_fade_chan

// File: rtl/led_fade_drv.sv
// Two-channel PWM LED fader fed by a flow-LED on/off pattern.
// Optional macro LED_FADE_ACTIVE_LOW_EN: invert led_out (inactive level 1,
// reset value 2'b11) for boards with active-low LEDs.
module led_fade_drv
  import led_fade_pkg::*;
#(
  parameter logic [15:0]       STEP_DIV = 16'd49000,
  parameter logic [DUTY_W-1:0] PWM_MAX  = 8'd255
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [1:0] led_in,
  output logic [1:0] led_out
);

`ifdef LED_FADE_ACTIVE_LOW_EN
  localparam logic [1:0] LED_INACT = 2'b11;
`else
  localparam logic [1:0] LED_INACT = 2'b00;
`endif

  localparam logic [15:0]       PRESC_LAST = STEP_DIV - 16'd1;
  localparam logic [DUTY_W-1:0] PWM_LAST   = PWM_MAX - 8'd1;

  logic [1:0]        led_q, led_d;
  logic [15:0]       presc_q, presc_d;
  logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [1:0]        led_out_q, led_out_d;
  logic              step_tick;

  fade_state_e       state_0, state_1;
  logic [DUTY_W-1:0] duty_0, duty_1;

  assign step_tick = (presc_q == PRESC_LAST);

  // Input register, prescaler, PWM counter and output register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_q     <= '0;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      led_out_q <= LED_INACT;
    end else begin
      led_q     <= led_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_out_q <= led_out_d;
    end
  end

  // Counter wrap logic and PWM compare.
  always_comb begin
    led_d     = led_in;
    presc_d   = step_tick ? 16'd0 : presc_q + 16'd1;
    pwm_cnt_d = (pwm_cnt_q >= PWM_LAST) ? '0 : pwm_cnt_q + 8'd1;
    led_out_d = {(pwm_cnt_q < duty_1), (pwm_cnt_q < duty_0)} ^ LED_INACT;
  end

  led_fade_chan #(.PWM_MAX(PWM_MAX)) u_ch0 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .led_i     (led_q[0]),
    .step_tick (step_tick),
    .state     (state_0),
    .duty      (duty_0)
  );

  led_fade_chan #(.PWM_MAX(PWM_MAX)) u_ch1 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .led_i     (led_q[1]),
    .step_tick (step_tick),
    .state     (state_1),
    .duty      (duty_1)
  );

  assign led_out = led_out_q;

endmodule : led_fade_drv

// File: tb/tb_led_fade_drv.sv
// Self-checking bench for led_fade_drv (STEP_DIV=2, PWM_MAX=255).
module tb_led_fade_drv;
  import led_fade_pkg::*;

`ifdef LED_FADE_ACTIVE_LOW_EN
  localparam logic [1:0] INACT = 2'b11;
`else
  localparam logic [1:0] INACT = 2'b00;
`endif

  logic       sys_clk;
  logic       sys_rst_n;
  logic [1:0] led_in;
  logic [1:0] led_out;

  int tests_run;
  int tests_failed;

  typedef struct {
    string name;
    int    val;
  } exp_t;
  exp_t sb[$];

  led_fade_drv #(.STEP_DIV(16'd2), .PWM_MAX(8'd255)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .led_in    (led_in),
    .led_out   (led_out)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input string name, input int val);
    exp_t e;
    e.name = name;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    int bad;
    exp_t e;
    sys_rst_n = 1'b0;
    led_in    = 2'b00;
    #12;
    push("reset_led_out", int'(INACT));
    e = sb.pop_front();
    tests_run++;
    if (int'(led_out) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, led_out, e.val);
    end
    sys_rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (led_out !== INACT) bad++;
      if (dut.u_ch0.state_q !== ST_OFF || dut.u_ch1.state_q !== ST_OFF) bad++;
      if (dut.u_ch0.duty_q !== 8'd0 || dut.u_ch1.duty_q !== 8'd0) bad++;
    end
    push("idle_2000_violations", 0);
    e = sb.pop_front();
    tests_run++;
    if (bad !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, bad, e.val);
    end
  endtask

  task automatic test_rise();
    int n, n_on, w1, w2, bad;
    bit done;
    exp_t e;
    led_in = 2'b01;
    push("rise_state_at_T2", int'(ST_RISE));
    tick();
    tick();
    e = sb.pop_front();
    tests_run++;
    if (int'(dut.u_ch0.state_q) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, dut.u_ch0.state_q, e.val);
    end
    n = 2; w1 = 0; w2 = 0; done = 0; n_on = 0;
    while (!done && n < 700) begin
      tick();
      n++;
      if (((led_out ^ INACT) & 2'b01) != 0) begin
        if (n >= 3 && n < 253) w1++;
        else if (n >= 253 && n < 503) w2++;
      end
      if (dut.u_ch0.state_q === ST_ON) begin
        done = 1;
        n_on = n;
      end
    end
    push("rise_on_time_in_510_514", 1);
    e = sb.pop_front();
    tests_run++;
    if (int'(done && n_on >= 510 && n_on <= 514) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: on at cycle %0d (reached=%0d) want 510..514", e.name, n_on, done);
    end
    push("rise_duty_full", 255);
    e = sb.pop_front();
    tests_run++;
    if (int'(dut.u_ch0.duty_q) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, dut.u_ch0.duty_q, e.val);
    end
    push("rise_high_fraction_increases", 1);
    e = sb.pop_front();
    tests_run++;
    if (int'(w2 > w1 && w1 > 0) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: window1=%0d window2=%0d want window2>window1>0", e.name, w1, w2);
    end
    push("rise_ch1_off", int'(ST_OFF));
    e = sb.pop_front();
    tests_run++;
    if (int'(dut.u_ch1.state_q) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, dut.u_ch1.state_q, e.val);
    end
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if ((led_out ^ INACT) !== 2'b01) bad++;
    end
    push("on_output_constant", 0);
    e = sb.pop_front();
    tests_run++;
    if (bad !== e.val) begin
      tests_failed++;
      $display("FAIL %s: %0d bad cycles want %0d", e.name, bad, e.val);
    end
  endtask

  task automatic test_fall();
    int n, n_off, bad;
    bit done;
    exp_t e;
    led_in = 2'b00;
    push("fall_state_at_T2", int'(ST_FALL));
    tick();
    tick();
    e = sb.pop_front();
    tests_run++;
    if (int'(dut.u_ch0.state_q) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, dut.u_ch0.state_q, e.val);
    end
    n = 2; done = 0; n_off = 0;
    while (!done && n < 700) begin
      tick();
      n++;
      if (dut.u_ch0.state_q === ST_OFF) begin
        done = 1;
        n_off = n;
      end
    end
    push("fall_off_time_in_510_514", 1);
    e = sb.pop_front();
    tests_run++;
    if (int'(done && n_off >= 510 && n_off <= 514) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: off at cycle %0d (reached=%0d) want 510..514", e.name, n_off, done);
    end
    push("fall_duty_zero", 0);
    e = sb.pop_front();
    tests_run++;
    if (int'(dut.u_ch0.duty_q) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, dut.u_ch0.duty_q, e.val);
    end
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (led_out !== INACT) bad++;
    end
    push("off_output_constant", 0);
    e = sb.pop_front();
    tests_run++;
    if (bad !== e.val) begin
      tests_failed++;
      $display("FAIL %s: %0d bad cycles want %0d", e.name, bad, e.val);
    end
  endtask

  // Turn-around mid-fade: wait for the edge on which duty steps onto the
  // target, flip led_in, then the FSM sees the change two edges later, on
  // the next step edge.
  task automatic reversal(input logic [7:0] target, input logic [1:0] new_in,
                          input int exp_after, input fade_state_e exp_st);
    int n, prev;
    bit found;
    exp_t e;
    n = 0; found = 0; prev = int'(dut.u_ch0.duty_q);
    while (!found && n < 700) begin
      tick();
      n++;
      if (int'(dut.u_ch0.duty_q) == int'(target) && prev != int'(target)) found = 1;
      prev = int'(dut.u_ch0.duty_q);
    end
    push($sformatf("reach_duty_%0d", target), 1);
    e = sb.pop_front();
    tests_run++;
    if (int'(found) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: reached=%0d want %0d", e.name, found, e.val);
    end
    led_in = new_in;
    push($sformatf("hold_duty_%0d", target), int'(target));
    push($sformatf("step_after_%0d", target), exp_after);
    push($sformatf("state_after_%0d", target), int'(exp_st));
    tick();
    e = sb.pop_front();
    tests_run++;
    if (int'(dut.u_ch0.duty_q) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, dut.u_ch0.duty_q, e.val);
    end
    tick();
    e = sb.pop_front();
    tests_run++;
    if (int'(dut.u_ch0.duty_q) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, dut.u_ch0.duty_q, e.val);
    end
    e = sb.pop_front();
    tests_run++;
    if (int'(dut.u_ch0.state_q) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, dut.u_ch0.state_q, e.val);
    end
  endtask

  task automatic test_reversal();
    led_in = 2'b01;
    reversal(8'd100, 2'b00, 99, ST_FALL);
    reversal(8'd90, 2'b01, 91, ST_RISE);
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int i = 0; i < 20; i++) tick();
    #2;
    sys_rst_n = 1'b0;
    push("async_led_out", int'(INACT));
    push("async_duty", 0);
    push("async_state", int'(ST_OFF));
    push("async_counters", 0);
    #1;
    e = sb.pop_front();
    tests_run++;
    if (int'(led_out) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, led_out, e.val);
    end
    e = sb.pop_front();
    tests_run++;
    if (int'(dut.u_ch0.duty_q) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, dut.u_ch0.duty_q, e.val);
    end
    e = sb.pop_front();
    tests_run++;
    if (int'(dut.u_ch0.state_q) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, dut.u_ch0.state_q, e.val);
    end
    e = sb.pop_front();
    tests_run++;
    if (int'(dut.presc_q) + int'(dut.pwm_cnt_q) + int'(dut.led_q) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: presc=%0d pwm=%0d led_q=%0d want all 0", e.name,
               dut.presc_q, dut.pwm_cnt_q, dut.led_q);
    end
    #2;
    sys_rst_n = 1'b1;
    push("restart_off_at_E1", int'(ST_OFF));
    push("restart_rise_at_E2", int'(ST_RISE));
    push("restart_duty_at_E2", 0);
    tick();
    e = sb.pop_front();
    tests_run++;
    if (int'(dut.u_ch0.state_q) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, dut.u_ch0.state_q, e.val);
    end
    tick();
    e = sb.pop_front();
    tests_run++;
    if (int'(dut.u_ch0.state_q) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, dut.u_ch0.state_q, e.val);
    end
    e = sb.pop_front();
    tests_run++;
    if (int'(dut.u_ch0.duty_q) !== e.val) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d", e.name, dut.u_ch0.duty_q, e.val);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    sys_rst_n    = 1'b0;
    led_in       = 2'b00;
    test_reset();
    test_rise();
    test_fall();
    test_reversal();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_led_fade_drv
